// File: rtl/cell_rx_pkg.sv
// Shared definitions for the MMC cell-voltage serial receiver: FSM states,
// default timing/limit constants, error-counter width, majority-vote helper.
package cell_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int unsigned DEF_BIT_CYCLES     = 5208;        // 50 MHz / 9600 Bd
    localparam int unsigned DEF_TIMEOUT_CYCLES = 25_000_000;  // 0.5 s at 50 MHz
    localparam logic [7:0]  DEF_OV_LIMIT       = 8'd230;
    localparam int unsigned ERR_CNT_W          = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for the asynchronous fibre line; resets to 1 (line idle).
module bit_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Double-register the raw input to settle metastability.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/cell_volt_rx.sv
// Cell-voltage 8N1 serial receiver (idle-high, LSB first) for one fibre input.
// Outputs a validated sample with strobe, framing-error strobe/counter,
// link-stale flag and overvoltage flag.
// Optional: CELL_RX_MAJORITY_EN selects 2-of-3 majority sampling at each bit point.
module cell_volt_rx
    import cell_rx_pkg::*;
#(
    parameter int unsigned BIT_CYCLES     = DEF_BIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [7:0]  OV_LIMIT       = DEF_OV_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 rx_in,
    output logic [7:0]           data,
    output logic                 valid,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 stale,
    output logic                 ov
);

    localparam int unsigned CW = $clog2(BIT_CYCLES);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_HALF = CW'(BIT_CYCLES / 2);
    localparam logic [CW-1:0] C_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);

    logic                 w_rx;
    logic                 w_bit;
    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic                 w_cnt_clr;
    logic                 w_shift;
    logic                 w_commit;
    logic                 w_ferr;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bitn;
    logic [7:0]           r_shift;
    logic                 r_h1;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_ov;
    logic [TW-1:0]        r_tcnt;
    logic                 r_stale;

    bit_sync u_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     (rx_in),
        .o_q     (w_rx)
    );

`ifdef CELL_RX_MAJORITY_EN
    logic r_h2;

    // Two-deep history of the synchronized line for majority voting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h1 <= 1'b1;
            r_h2 <= 1'b1;
        end else if (clr) begin
            r_h1 <= 1'b1;
            r_h2 <= 1'b1;
        end else begin
            r_h1 <= w_rx;
            r_h2 <= r_h1;
        end
    end

    // Vote is centred on the previous cycle so decisions land on the same
    // clock as single-sample mode, keeping valid/frame_err timing identical.
    assign w_bit = maj3(r_h2, r_h1, w_rx);
`else
    // Previous synchronized line value for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     r_h1 <= 1'b1;
        else if (clr) r_h1 <= 1'b1;
        else          r_h1 <= w_rx;
    end

    assign w_bit = w_rx;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     r_state <= ST_IDLE;
        else if (clr) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rx && r_h1) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (r_cnt == C_HALF) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bitn == 3'd7) w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_clr = 1'b1;
                    if (w_bit) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                w_cnt_clr = 1'b1;
                if (w_rx) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bit-period counter, restarted at every sample point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_cnt <= '0;
        else if (clr || w_cnt_clr) r_cnt <= '0;
        else                       r_cnt <= r_cnt + 1'b1;
    end

    // Data-bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bitn  <= '0;
            r_shift <= '0;
        end else if (clr) begin
            r_bitn  <= '0;
            r_shift <= '0;
        end else begin
            if (r_state != ST_DATA) r_bitn <= '0;
            else if (w_shift)       r_bitn <= r_bitn + 1'b1;
            if (w_shift) r_shift <= {w_bit, r_shift[7:1]};
        end
    end

    // Committed sample, strobes, overvoltage flag and saturating error count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_err_cnt <= '0;
            r_ov      <= 1'b0;
        end else if (clr) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_err_cnt <= '0;
            r_ov      <= 1'b0;
        end else begin
            r_valid <= w_commit;
            r_ferr  <= w_ferr;
            if (w_commit) begin
                r_data <= r_shift;
                r_ov   <= (r_shift > OV_LIMIT);
            end
            if (w_ferr && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    // Link-timeout counter; stale is registered so it drops together with valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tcnt  <= '0;
            r_stale <= 1'b1;
        end else if (clr) begin
            r_tcnt  <= '0;
            r_stale <= 1'b1;
        end else if (w_commit) begin
            r_tcnt  <= '0;
            r_stale <= 1'b0;
        end else if (r_tcnt != T_MAX) begin
            r_tcnt <= r_tcnt + 1'b1;
            if (r_tcnt == T_MAX - TW'(1)) r_stale <= 1'b1;
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign err_cnt   = r_err_cnt;
    assign stale     = r_stale;
    assign ov        = r_ov;

endmodule
